// File: rtl/oam_dma_if.sv
// CPU-side and databus-side signals of the sprite OAM DMA engine.
// Combinational bus mux path, no internal latency of its own.
// RDY is the only backpressure: low halts the CPU while the engine owns the bus.
interface oam_dma_if;
   // CPU side (T65)
   logic [15:0] CPU_ADDR;
   logic        CPU_RW_N;
   logic [7:0]  CPU_DO;
   logic        RDY;
   // Databus side
   logic [7:0]  BUS_DI;
   logic [15:0] BUS_ADDR;
   logic        BUS_RW_N;
   logic [7:0]  BUS_DO;
   // Engine status
   logic        DMA_ACTIVE;

   // System side: CPU plus databus decoder
   modport master (
      output CPU_ADDR, CPU_RW_N, CPU_DO, BUS_DI,
      input  RDY, DMA_ACTIVE, BUS_ADDR, BUS_RW_N, BUS_DO
   );

   // The DMA engine itself
   modport slave (
      input  CPU_ADDR, CPU_RW_N, CPU_DO, BUS_DI,
      output RDY, DMA_ACTIVE, BUS_ADDR, BUS_RW_N, BUS_DO
   );
endinterface

// File: rtl/oam_dma.sv
// Sprite OAM DMA: a CPU write to TRIG_ADDR copies one page of CPU memory to OAM_PORT.
// Stall is 1 + 2*XFER_LEN cycles, plus one alignment cycle when the halt lands on odd parity.
// The CPU is held via RDY=0 for the whole transfer; idle cycles pass the CPU bus straight through.
module oam_dma #(
   parameter logic [15:0] TRIG_ADDR = 16'h4014,
   parameter logic [15:0] OAM_PORT  = 16'h2004,
   parameter int          XFER_LEN  = 256
) (
   input  logic   Clk,
   input  logic   Reset,
   oam_dma_if.slave bus
);

   // Index of the final byte; the 8-bit index wraps back to 0 after it.
   localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HALT,
      S_ALIGN,
      S_READ,
      S_WRITE
   } state_t;

   state_t      r_state;
   logic        r_parity;
   logic [7:0]  r_page;
   logic [7:0]  r_idx;
   logic [7:0]  r_latch;
   logic        r_rdy;
   logic        r_dma_active;

   logic        w_trigger;
   logic        w_last;
   logic [15:0] w_bus_addr;
   logic        w_bus_rw_n;
   logic [7:0]  w_bus_do;

   // Only a genuine CPU write to the trigger address while idle starts a transfer;
   // reads of it, and writes while busy, are ignored.
   assign w_trigger = (r_state == S_IDLE) && !bus.CPU_RW_N && (bus.CPU_ADDR == TRIG_ADDR);
   assign w_last    = (r_idx == LAST_IDX);

   // Cycle parity: free-running toggle, decides whether an alignment cycle is needed.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_parity <= 1'b0;
      end else begin
         r_parity <= ~r_parity;
      end
   end

   // Transfer state machine; RDY and DMA_ACTIVE are registered alongside the next state.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state      <= S_IDLE;
         r_page       <= 8'h00;
         r_idx        <= 8'h00;
         r_latch      <= 8'h00;
         r_rdy        <= 1'b1;
         r_dma_active <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_trigger) begin
                  r_page       <= bus.CPU_DO;
                  r_state      <= S_HALT;
                  r_rdy        <= 1'b0;
                  r_dma_active <= 1'b0;
               end
            end
            S_HALT: begin
               // An odd-parity halt needs one dummy cycle before the first read.
               r_state      <= r_parity ? S_ALIGN : S_READ;
               r_rdy        <= 1'b0;
               r_dma_active <= 1'b1;
            end
            S_ALIGN: begin
               r_state      <= S_READ;
               r_rdy        <= 1'b0;
               r_dma_active <= 1'b1;
            end
            S_READ: begin
               // Read data is valid in the same cycle as the address.
               r_latch      <= bus.BUS_DI;
               r_state      <= S_WRITE;
               r_rdy        <= 1'b0;
               r_dma_active <= 1'b1;
            end
            S_WRITE: begin
               if (w_last) begin
                  // Never advance into the next page: the last write ends the transfer.
                  r_idx        <= 8'h00;
                  r_state      <= S_IDLE;
                  r_rdy        <= 1'b1;
                  r_dma_active <= 1'b0;
               end else begin
                  r_idx        <= r_idx + 8'd1;
                  r_state      <= S_READ;
                  r_rdy        <= 1'b0;
                  r_dma_active <= 1'b1;
               end
            end
            default: begin
               r_state      <= S_IDLE;
               r_idx        <= 8'h00;
               r_rdy        <= 1'b1;
               r_dma_active <= 1'b0;
            end
         endcase
      end
   end

   // Bus mux: the CPU owns the bus in IDLE/HALT (so the trigger write itself reaches
   // the databus); the engine drives it in ALIGN/READ/WRITE.
   always_comb begin
      w_bus_addr = bus.CPU_ADDR;
      w_bus_rw_n = bus.CPU_RW_N;
      w_bus_do   = bus.CPU_DO;
      case (r_state)
         S_ALIGN: begin
            w_bus_addr = bus.CPU_ADDR;
            w_bus_rw_n = 1'b1;
         end
         S_READ: begin
            w_bus_addr = {r_page, r_idx};
            w_bus_rw_n = 1'b1;
         end
         S_WRITE: begin
            w_bus_addr = OAM_PORT;
            w_bus_rw_n = 1'b0;
            w_bus_do   = r_latch;
         end
         default: begin
            w_bus_addr = bus.CPU_ADDR;
            w_bus_rw_n = bus.CPU_RW_N;
            w_bus_do   = bus.CPU_DO;
         end
      endcase
   end

   assign bus.BUS_ADDR   = w_bus_addr;
   assign bus.BUS_RW_N   = w_bus_rw_n;
   assign bus.BUS_DO     = w_bus_do;
   assign bus.RDY        = r_rdy;
   assign bus.DMA_ACTIVE = r_dma_active;

endmodule

// File: tb/tb_oam_dma.sv
// Testbench for oam_dma: sysram model on the databus, OAM writes captured and
// compared with the page contents; stall lengths derived from cycle parity.
module tb_oam_dma;

   localparam logic [15:0] TRIG  = 16'h4014;
   localparam logic [15:0] OAM   = 16'h2004;
   localparam logic [15:0] IDLEA = 16'h8123;

   logic Clk = 1'b0;
   logic Reset = 1'b1;

   oam_dma_if bus ();

   oam_dma #(
      .TRIG_ADDR (TRIG),
      .OAM_PORT  (OAM),
      .XFER_LEN  (256)
   ) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   always #5 Clk = ~Clk;

   // System RAM seen on the databus (reads only matter here).
   logic [7:0] mem [0:65535];
   assign bus.BUS_DI = mem[bus.BUS_ADDR];

   int checks = 0;
   int errors = 0;

   // Cycles since the last reset edge; its LSB is the parity of the current cycle.
   int unsigned cyc = 0;
   always @(posedge Clk) begin
      if (Reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   task automatic drive_cpu(input logic [15:0] a, input logic rw, input logic [7:0] d);
      bus.CPU_ADDR = a;
      bus.CPU_RW_N = rw;
      bus.CPU_DO   = d;
   endtask

   // Trigger a transfer from 'page' with the HALT cycle on the requested parity and
   // check the whole stall; optionally retrigger mid-transfer or reset during WRITE of $80.
   task automatic run_xfer(input logic [7:0] page, input bit want_odd, input bit inject,
                           input bit abort80, input string nm);
      logic [15:0] rd_q[$];
      logic [7:0]  wr_q[$];
      int stall = 0, halt_n = 0, bad_wr = 0, bad_rdy = 0, nrd = 0;
      bit done = 0, aborted = 0;
      logic [15:0] exp_a;
      logic [7:0]  exp_d;
      int ofs;
      ofs = want_odd ? 1 : 0;

      @(posedge Clk); #1;
      // HALT parity is the opposite of the trigger cycle's parity.
      if (cyc[0] == want_odd) begin
         drive_cpu(IDLEA, 1'b1, 8'h00);
         @(posedge Clk); #1;
      end
      drive_cpu(TRIG, 1'b0, page);
      @(negedge Clk);
      checks++;
      if (bus.RDY !== 1'b1 || bus.BUS_ADDR !== TRIG || bus.BUS_RW_N !== 1'b0 || bus.BUS_DO !== page) begin
         errors++;
         $display("FAIL %s trigger passthrough: rdy=%b addr=%h rw=%b do=%h, required rdy=1 addr=%h rw=0 do=%h",
                  nm, bus.RDY, bus.BUS_ADDR, bus.BUS_RW_N, bus.BUS_DO, TRIG, page);
      end

      for (int c = 0; c < 700 && !done; c++) begin
         @(posedge Clk); #1;
         nrd = (rd_q.size() > ofs) ? rd_q.size() - ofs : 0;
         drive_cpu(IDLEA, 1'b1, 8'h00);
         if (inject && nrd == 'h40) drive_cpu(TRIG, 1'b0, 8'h07);
         if (abort80 && nrd == 'h81 && wr_q.size() == 'h80) Reset = 1'b1;
         @(negedge Clk);
         if (!bus.RDY) stall++;
         if (!bus.RDY && !bus.DMA_ACTIVE) halt_n++;
         if (bus.DMA_ACTIVE && bus.RDY) bad_rdy++;
         if (bus.DMA_ACTIVE && bus.BUS_RW_N) rd_q.push_back(bus.BUS_ADDR);
         if (bus.DMA_ACTIVE && !bus.BUS_RW_N) begin
            wr_q.push_back(bus.BUS_DO);
            if (bus.BUS_ADDR !== OAM) bad_wr++;
         end
         if (Reset) begin done = 1; aborted = 1; end
         else if (bus.RDY) done = 1;
      end

      checks++;
      if (!done) begin
         errors++;
         $display("FAIL %s timeout: transfer did not end within 700 cycles (stall=%0d)", nm, stall);
      end

      checks++;
      if (bad_wr != 0 || bad_rdy != 0) begin
         errors++;
         $display("FAIL %s bus ownership: %0d writes not to $2004, %0d active cycles with RDY=1, required 0 and 0",
                  nm, bad_wr, bad_rdy);
      end

      checks++;
      if (halt_n != 1) begin
         errors++;
         $display("FAIL %s halt cycles: got %0d, required 1", nm, halt_n);
      end

      // Every captured OAM write must carry the page byte of the same index.
      for (int i = 0; i < wr_q.size(); i++) begin
         exp_d = mem[{page, 8'(i)}];
         checks++;
         if (wr_q[i] !== exp_d) begin
            errors++;
            $display("FAIL %s oam byte %0d: got %h, required %h", nm, i, wr_q[i], exp_d);
         end
      end
      // Read cycles: optional ALIGN (CPU address) then $XX00.. in order.
      for (int j = 0; j < rd_q.size(); j++) begin
         exp_a = (want_odd && j == 0) ? IDLEA : {page, 8'(j - ofs)};
         checks++;
         if (rd_q[j] !== exp_a) begin
            errors++;
            $display("FAIL %s read cycle %0d: addr %h, required %h", nm, j, rd_q[j], exp_a);
         end
      end

      if (abort80) begin
         checks++;
         if (!aborted || wr_q.size() != 'h81) begin
            errors++;
            $display("FAIL %s abort point: aborted=%0d writes=%0d, required 1 and 129", nm, aborted, wr_q.size());
         end
         @(posedge Clk); #1;
         Reset = 1'b0;
         drive_cpu(IDLEA, 1'b1, 8'h00);
         @(negedge Clk);
         checks++;
         if (bus.RDY !== 1'b1 || bus.DMA_ACTIVE !== 1'b0 || bus.BUS_ADDR !== IDLEA) begin
            errors++;
            $display("FAIL %s after reset: rdy=%b act=%b addr=%h, required 1 0 %h",
                     nm, bus.RDY, bus.DMA_ACTIVE, bus.BUS_ADDR, IDLEA);
         end
      end else begin
         checks++;
         if (stall != 513 + ofs) begin
            errors++;
            $display("FAIL %s stall length: got %0d, required %0d", nm, stall, 513 + ofs);
         end
         checks++;
         if (wr_q.size() != 256 || rd_q.size() != 256 + ofs) begin
            errors++;
            $display("FAIL %s counts: writes=%0d reads=%0d, required 256 and %0d",
                     nm, wr_q.size(), rd_q.size(), 256 + ofs);
         end
         checks++;
         if (rd_q.size() == 0 || rd_q[rd_q.size()-1] !== {page, 8'hFF}) begin
            errors++;
            $display("FAIL %s last read: got %h, required %h", nm,
                     (rd_q.size() == 0) ? 16'hxxxx : rd_q[rd_q.size()-1], {page, 8'hFF});
         end
         checks++;
         if (bus.DMA_ACTIVE !== 1'b0 || bus.BUS_ADDR !== IDLEA || bus.BUS_RW_N !== 1'b1) begin
            errors++;
            $display("FAIL %s end passthrough: act=%b addr=%h rw=%b, required 0 %h 1",
                     nm, bus.DMA_ACTIVE, bus.BUS_ADDR, bus.BUS_RW_N, IDLEA);
         end
      end
   endtask

   task automatic test_reset();
      logic [15:0] a;
      logic [7:0]  d;
      Reset = 1'b1;
      drive_cpu(IDLEA, 1'b1, 8'h00);
      repeat (2) @(posedge Clk);
      #1 Reset = 1'b0;
      @(negedge Clk);
      checks++;
      if (bus.RDY !== 1'b1 || bus.DMA_ACTIVE !== 1'b0 || bus.BUS_ADDR !== IDLEA || bus.BUS_RW_N !== 1'b1) begin
         errors++;
         $display("FAIL reset state: rdy=%b act=%b addr=%h rw=%b, required 1 0 %h 1",
                  bus.RDY, bus.DMA_ACTIVE, bus.BUS_ADDR, bus.BUS_RW_N, IDLEA);
      end
      // Passthrough is combinational: change inputs mid-cycle and look again.
      a = {4'h9, 12'($urandom)};
      d = 8'($urandom);
      drive_cpu(a, 1'b0, d);
      #1;
      checks++;
      if (bus.BUS_ADDR !== a || bus.BUS_RW_N !== 1'b0 || bus.BUS_DO !== d) begin
         errors++;
         $display("FAIL idle passthrough: addr=%h rw=%b do=%h, required %h 0 %h",
                  bus.BUS_ADDR, bus.BUS_RW_N, bus.BUS_DO, a, d);
      end
      drive_cpu(IDLEA, 1'b1, 8'h00);
   endtask

   task automatic test_no_trigger();
      logic [15:0] addrs [4];
      logic        rws   [4];
      addrs = '{16'h4014, 16'h4015, 16'h4013, 16'h6014};
      rws   = '{1'b1, 1'b0, 1'b0, 1'b0};
      for (int k = 0; k < 4; k++) begin
         @(posedge Clk); #1;
         drive_cpu(addrs[k], rws[k], 8'h02);
         @(negedge Clk);
         @(posedge Clk); #1;
         drive_cpu(IDLEA, 1'b1, 8'h00);
         @(negedge Clk);
         checks++;
         if (bus.RDY !== 1'b1 || bus.DMA_ACTIVE !== 1'b0) begin
            errors++;
            $display("FAIL no-trigger %h rw=%b: rdy=%b act=%b, required 1 0",
                     addrs[k], rws[k], bus.RDY, bus.DMA_ACTIVE);
         end
      end
      // Trigger presented together with Reset: reset wins.
      @(posedge Clk); #1;
      Reset = 1'b1;
      drive_cpu(TRIG, 1'b0, 8'h05);
      @(posedge Clk); #1;
      Reset = 1'b0;
      drive_cpu(IDLEA, 1'b1, 8'h00);
      repeat (3) begin
         @(negedge Clk);
         checks++;
         if (bus.RDY !== 1'b1 || bus.DMA_ACTIVE !== 1'b0) begin
            errors++;
            $display("FAIL trigger with reset: rdy=%b act=%b, required 1 0", bus.RDY, bus.DMA_ACTIVE);
         end
         @(posedge Clk); #1;
      end
      @(negedge Clk);
   endtask

   task automatic test_even();
      for (int i = 0; i < 256; i++) mem[16'h0200 + 16'(i)] = 8'(i) ^ 8'hA5;
      run_xfer(8'h02, 1'b0, 1'b0, 1'b0, "even");
   endtask

   task automatic test_odd();
      run_xfer(8'h02, 1'b1, 1'b0, 1'b0, "odd");
   endtask

   task automatic test_retrigger();
      run_xfer(8'h03, 1'b0, 1'b1, 1'b0, "retrigger");
   endtask

   task automatic test_reset_mid();
      run_xfer(8'h03, 1'b1, 1'b0, 1'b1, "reset_mid");
      run_xfer(8'h03, 1'b0, 1'b0, 1'b0, "restart");
   endtask

   task automatic test_random();
      logic [7:0] pg;
      for (int r = 0; r < 4; r++) begin
         pg = 8'($urandom);
         for (int i = 0; i < 256; i++) mem[{pg, 8'(i)}] = 8'($urandom);
         run_xfer(pg, 1'($urandom), 1'b0, 1'b0, "random");
      end
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
      drive_cpu(IDLEA, 1'b1, 8'h00);
      test_reset();
      test_no_trigger();
      test_even();
      test_odd();
      test_retrigger();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/oam_dma.md
Name: oam_dma

Overview:
- Sprite OAM DMA engine. Sits between the T65 CPU and the databus decoder.
- Detects a CPU write to $4014 and halts the CPU through Rdy.
- Copies 256 bytes from CPU page $XX00-$XXFF to the PPU OAM data port ($2004), one read/write pair per byte.
- When idle it passes the CPU address, R/W and data straight through to the databus.

Parameters:
TRIG_ADDR, 16'h4014, CPU write address that starts a transfer
OAM_PORT, 16'h2004, destination address written for every byte
XFER_LEN, 256, bytes per transfer; power of two, max 256

Ports:
Clk  in  1  CPU clock (CLK_NES)
Reset  in  1  synchronous, active-high
CPU_ADDR  in  16  CPU address (T65 A[15:0])
CPU_RW_N  in  1  CPU R/W: 1 = read, 0 = write
CPU_DO  in  8  CPU write data
BUS_DI  in  8  databus read data, valid in the same cycle as BUS_ADDR
RDY  out  1  to T65 Rdy; 0 = CPU halted
DMA_ACTIVE  out  1  1 while the engine owns the bus
BUS_ADDR  out  16  address to databus
BUS_RW_N  out  1  R/W to databus
BUS_DO  out  8  write data to databus

Behaviour:
- Reset (sync, dominant over all other inputs):
  - state=IDLE, PARITY=0, PAGE=0, IDX=0, LATCH=0.
  - RDY=1, DMA_ACTIVE=0.
- Bus mux (combinational):
  - IDLE and HALT: BUS_ADDR=CPU_ADDR, BUS_RW_N=CPU_RW_N, BUS_DO=CPU_DO.
  - ALIGN: BUS_ADDR=CPU_ADDR, BUS_RW_N=1.
  - READ: BUS_ADDR={PAGE,IDX}, BUS_RW_N=1, BUS_DO=CPU_DO.
  - WRITE: BUS_ADDR=OAM_PORT, BUS_RW_N=0, BUS_DO=LATCH.
- PARITY toggles every Clk; cleared by Reset.
- Trigger:
  - In IDLE, an edge with CPU_RW_N=0 and CPU_ADDR==TRIG_ADDR latches PAGE<=CPU_DO and goes to HALT.
  - The $4014 write itself still passes to the databus.
- Outputs by state:
  - RDY=0 in HALT, ALIGN, READ and WRITE; RDY=1 in IDLE.
  - DMA_ACTIVE=1 in ALIGN, READ and WRITE only.
- State machine:
  - IDLE -> HALT on trigger.
  - HALT (1 cycle): -> ALIGN if PARITY==1 in this cycle, else -> READ.
  - ALIGN (1 cycle): -> READ.
  - READ: LATCH<=BUS_DI at the end of the cycle; -> WRITE.
  - WRITE: IDX<=IDX+1. If IDX==XFER_LEN-1 -> IDLE and IDX<=0; else -> READ.
- Stall length:
  - CPU sees RDY=0 for 1+2*XFER_LEN cycles (513) when HALT is at even parity.
  - 514 cycles when HALT is at odd parity.
- IDX is 8 bits. Reads never cross the page: $XXFF is followed by WRITE and then IDLE, never a read of $(XX+1)00.
- In non-IDLE states, writes to TRIG_ADDR are ignored (no restart, PAGE unchanged).
- Trigger and Reset in the same cycle: Reset wins and no transfer starts.
- Reset mid-transfer: IDLE on the next edge, RDY=1; the partial OAM contents are left as written.
- Reads of TRIG_ADDR (CPU_RW_N=1) never trigger.

Test Plan:
- Reset held 2 cycles, then released -> RDY=1, DMA_ACTIVE=0; BUS_ADDR tracks CPU_ADDR=16'h8123 combinationally.
- CPU writes $02 to $4014 with HALT at even parity, sysram $0200+i = i^8'hA5:
  - RDY low for exactly 513 cycles.
  - 256 writes to $2004 with data 8'hA5, 8'hA4, ... in order.
  - Last read address $02FF; RDY=1 on the next cycle.
- Same transfer with HALT at odd parity -> one ALIGN cycle with BUS_RW_N=1 and DMA_ACTIVE=1; RDY low for exactly 514 cycles.
- Mid-transfer, with IDX=8'h40 (read cycles at $0340 after a $03 trigger), the CPU inputs present a write of $07 to $4014 -> ignored; the transfer continues to $03FF and PAGE stays $03.
- Reset asserted during WRITE of IDX=8'h80 -> next cycle IDLE, RDY=1, BUS_ADDR=CPU_ADDR. A new $4014 write then starts the transfer again from IDX=0.
- CPU read of $4014, and a write to $4015 -> no transfer; RDY stays 1.
